memd_load_arbiter: RTL and testbench

Shares the single data-memory read port (memd, combinational read, address width MEMD_SIZE_LOG) among several load requesters, such as load-queue entries or reservation-station issue slots of the out-of-order core.
- Grants at most one load per cycle using round-robin priority.
- Drives the memory address and captures the read data in the grant cycle.
- Returns the data, tagged, after a fixed pipeline latency.
- Supports flushing in-flight loads on misprediction squash.

---
 rtl/memd_load_arbiter.sv | 145 ++++++++++++++
 tb/tb_memd_load_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memd_load_arbiter.sv
// memd_load_arbiter: shares the single combinational memd read port among
// NUM_REQ load requesters. It grants one load per cycle in round-robin order,
// captures mem_rdata in the grant cycle, and returns {id, tag, data} after LAT
// cycles. flush squashes every load still in flight.
// Optional build macro MEMD_ARB_RESP_READY_EN adds a resp_ready back-pressure
// input. While a response is shown but not accepted, the whole pipeline holds
// and no new grant is issued.
module memd_load_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int TAG_W   = 3,
  parameter int LAT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_rdata,
`ifdef MEMD_ARB_RESP_READY_EN
  input  logic                         resp_ready,
`endif
  output logic                         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [TAG_W-1:0]             resp_tag,
  output logic [DATA_W-1:0]            resp_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              vld_q  [LAT];
  logic              vld_d  [LAT];
  logic [ID_W-1:0]   id_q   [LAT];
  logic [ID_W-1:0]   id_d   [LAT];
  logic [TAG_W-1:0]  tag_q  [LAT];
  logic [TAG_W-1:0]  tag_d  [LAT];
  logic [DATA_W-1:0] data_q [LAT];
  logic [DATA_W-1:0] data_d [LAT];

  logic              stall;
  logic              grant_ok;
  logic              grant;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   scan_idx;

  // The oldest stage is shown on the response port. It stalls only when it is
  // valid and the consumer refuses it.
`ifdef MEMD_ARB_RESP_READY_EN
  assign stall = vld_q[LAT-1] & ~resp_ready;
`else
  assign stall = 1'b0;
`endif

  // Priority order: rst, then flush, then stall. Each of these blocks a grant.
  assign grant_ok = ~rst & ~flush & ~stall;
  assign grant    = grant_ok & win_found;

  // Round-robin scan: find the first valid requester, starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ptr_q + ID_W'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Decode the winner into the one-hot ready and the memd read address.
  always_comb begin
    req_ready = '0;
    mem_addr  = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
      mem_addr           = req_addr[win_idx*ADDR_W +: ADDR_W];
    end
  end

  // Next state: advance the pointer past the winner and shift the return
  // pipeline. A flush squashes every stage. A stall freezes every stage.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < LAT; i++) begin
      vld_d[i]  = vld_q[i];
      id_d[i]   = id_q[i];
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
    end
    if (grant) begin
      ptr_d = win_idx + ID_W'(1);
    end
    if (flush) begin
      for (int i = 0; i < LAT; i++) begin
        vld_d[i] = 1'b0;
      end
    end else if (!stall) begin
      vld_d[0]  = grant;
      id_d[0]   = win_idx;
      tag_d[0]  = req_tag[win_idx*TAG_W +: TAG_W];
      data_d[0] = mem_rdata;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i]  = vld_q[i-1];
        id_d[i]   = id_q[i-1];
        tag_d[i]  = tag_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  // State registers. A reset discards every outstanding load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        vld_q[i]  <= 1'b0;
        id_q[i]   <= '0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < LAT; i++) begin
        vld_q[i]  <= vld_d[i];
        id_q[i]   <= id_d[i];
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign resp_valid = vld_q[LAT-1];
  assign resp_id    = id_q[LAT-1];
  assign resp_tag   = tag_q[LAT-1];
  assign resp_data  = data_q[LAT-1];

endmodule

// File: tb/tb_memd_load_arbiter.sv
// Testbench for memd_load_arbiter. It runs a directed vector table, then a
// randomized run checked against a queue-based reference model.
// The stall sequences are compiled in only when MEMD_ARB_RESP_READY_EN is defined.
module tb_memd_load_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 4;
  localparam int TAG_W   = 3;
  localparam int LAT     = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      rr;
  logic                      resp_valid;
  logic [1:0]                resp_id;
  logic [TAG_W-1:0]          resp_tag;
  logic [DATA_W-1:0]         resp_data;

  logic [DATA_W-1:0]         mem [4];

  int n_chk  = 0;
  int n_fail = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  memd_load_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_tag(req_tag),
    .req_ready(req_ready),
    .flush(flush),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
`ifdef MEMD_ARB_RESP_READY_EN
    .resp_ready(rr),
`endif
    .resp_valid(resp_valid),
    .resp_id(resp_id),
    .resp_tag(resp_tag),
    .resp_data(resp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        f;
    logic [3:0]  v;
    logic [7:0]  a;
    logic [11:0] t;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [2:0]  tg;
    logic [3:0]  d;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic [3:0] v, input logic [7:0] a,
                     input logic [11:0] t, input logic [3:0] rdy, input logic rv,
                     input logic [1:0] id, input logic [2:0] tg, input logic [3:0] d);
    vec_t e;
    e.r = r; e.f = f; e.v = v; e.a = a; e.t = t;
    e.rdy = rdy; e.rv = rv; e.id = id; e.tg = tg; e.d = d;
    tbl.push_back(e);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int tag;
    int data;
    int rem;
  } ent_t;
  ent_t q[$];
  int   mptr = 0;

  // One clock cycle: compare the DUT outputs with the model, then step the model at the edge.
  task automatic model_cycle(input string nm);
    logic vis, stl, g;
    int   w;
    ent_t ne;
    @(negedge clk);
    vis = (q.size() > 0) && (q[0].rem == 0);
    stl = vis && !rr;
    g = 1'b0;
    w = 0;
    if (!rst && !flush && !stl) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (mptr + k) % NUM_REQ;
        if (!g && req_valid[i]) begin
          g = 1'b1;
          w = i;
        end
      end
    end
    chk({nm, "_ready"}, 32'(req_ready), g ? 32'(1 << w) : 32'd0);
    if (g) chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(req_addr[w*ADDR_W +: ADDR_W]));
    else if (req_valid == '0) chk({nm, "_mem_addr_idle"}, 32'(mem_addr), 32'd0);
    chk({nm, "_resp_valid"}, 32'(resp_valid), 32'(vis));
    if (vis) begin
      chk({nm, "_resp_id"},   32'(resp_id),   32'(q[0].id));
      chk({nm, "_resp_tag"},  32'(resp_tag),  32'(q[0].tag));
      chk({nm, "_resp_data"}, 32'(resp_data), 32'(q[0].data));
    end
    ne.id   = w;
    ne.tag  = int'(req_tag[w*TAG_W +: TAG_W]);
    ne.data = int'(mem[req_addr[w*ADDR_W +: ADDR_W]]);
    ne.rem  = LAT - 1;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mptr = 0;
    end else if (flush) begin
      q.delete();
    end else if (!stl) begin
      if (vis) void'(q.pop_front());
      foreach (q[i]) q[i].rem--;
      if (g) begin
        q.push_back(ne);
        mptr = (w + 1) % NUM_REQ;
      end
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_tag = '0; rr = 1'b1;
    mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5; mem[3] = 4'hC;

    // Single load: addr 1, tag 5, returned two cycles after the grant.
    add(1, 0, 4'b0000, 8'h01, 12'h005, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0001, 8'h01, 12'h005, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'h01, 12'h005, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'h01, 12'h005, 4'b0000, 1, 0, 5, 4'hA);
    add(1, 0, 4'b0000, 8'h01, 12'h005, 4'b0000, 0, 0, 0, 0);
    // All requesters valid for 8 cycles, starting from ptr=0.
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0010, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0100, 1, 0, 1, 4'h3);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b1000, 1, 1, 2, 4'hA);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0001, 1, 2, 3, 4'h5);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0010, 1, 3, 4, 4'hC);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0100, 1, 0, 1, 4'h3);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b1000, 1, 1, 2, 4'hA);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 2, 3, 4'h5);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 3, 4, 4'hC);
    // Move ptr to 2, then requesters 1 and 3 valid: grants alternate 3, 1, 3, 1.
    add(0, 0, 4'b0010, 8'he4, 12'h8d1, 4'b0010, 0, 0, 0, 0);
    add(0, 0, 4'b1010, 8'he4, 12'h8d1, 4'b1000, 0, 0, 0, 0);
    add(0, 0, 4'b1010, 8'he4, 12'h8d1, 4'b0010, 1, 1, 2, 4'hA);
    add(0, 0, 4'b1010, 8'he4, 12'h8d1, 4'b1000, 1, 3, 4, 4'hC);
    add(0, 0, 4'b1010, 8'he4, 12'h8d1, 4'b0010, 1, 1, 2, 4'hA);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 3, 4, 4'hC);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 1, 2, 4'hA);
    // Grant, then flush the next cycle: the squashed load never returns.
    add(0, 0, 4'b0001, 8'he4, 12'h8d1, 4'b0001, 0, 0, 0, 0);
    add(0, 1, 4'b0001, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0001, 8'he4, 12'h8d1, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 0, 1, 4'h3);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    // Flush while a response is showing: it stays visible, the younger load dies.
    add(0, 0, 4'b0001, 8'he4, 12'h8d1, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 4'b0010, 8'he4, 12'h8d1, 4'b0010, 0, 0, 0, 0);
    add(0, 1, 4'b0100, 8'he4, 12'h8d1, 4'b0000, 1, 0, 1, 4'h3);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    // Reset mid-flight: the pending load is dropped, and ptr returns to 0.
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0100, 0, 0, 0, 0);
    add(0, 0, 4'b0100, 8'he4, 12'h8d1, 4'b0100, 0, 0, 0, 0);
    add(1, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0000, 1, 2, 3, 4'h5);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 8'he4, 12'h8d1, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 1, 0, 1, 4'h3);
    add(0, 0, 4'b0000, 8'he4, 12'h8d1, 4'b0000, 0, 0, 0, 0);

    foreach (tbl[r]) begin
      rst = tbl[r].r; flush = tbl[r].f; req_valid = tbl[r].v;
      req_addr = tbl[r].a; req_tag = tbl[r].t;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_resp_valid", r), 32'(resp_valid), 32'(tbl[r].rv));
      if (tbl[r].rv) begin
        chk($sformatf("tbl%0d_resp_id", r),   32'(resp_id),   32'(tbl[r].id));
        chk($sformatf("tbl%0d_resp_tag", r),  32'(resp_tag),  32'(tbl[r].tg));
        chk($sformatf("tbl%0d_resp_data", r), 32'(resp_data), 32'(tbl[r].d));
      end
      @(posedge clk);
      #1;
    end

    // Synchronise the model with a reset cycle.
    rst = 1'b1; flush = 1'b0; req_valid = '0; rr = 1'b1;
    model_cycle("sync");
    rst = 1'b0;

`ifdef MEMD_ARB_RESP_READY_EN
    // Consumer refuses for 3 cycles while requesters keep asking, then drains.
    req_valid = 4'b1111; req_addr = 8'he4; req_tag = 12'h8d1;
    for (int c = 0; c < 2; c++) model_cycle("stall_fill");
    rr = 1'b0;
    for (int c = 0; c < 3; c++) model_cycle("stall_hold");
    rr = 1'b1; req_valid = '0;
    for (int c = 0; c < 4; c++) model_cycle("stall_drain");
    // Flush while stalled clears the pipeline.
    req_valid = 4'b0011;
    for (int c = 0; c < 2; c++) model_cycle("sflush_fill");
    rr = 1'b0; req_valid = '0;
    model_cycle("sflush_hold");
    flush = 1'b1;
    model_cycle("sflush_flush");
    flush = 1'b0; rr = 1'b1;
    for (int c = 0; c < 3; c++) model_cycle("sflush_after");
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      req_valid = 4'($urandom_range(0, 15));
      req_addr  = 8'($urandom);
      req_tag   = 12'($urandom);
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 3)] = 4'($urandom);
`ifdef MEMD_ARB_RESP_READY_EN
      rr = ($urandom_range(0, 3) != 0);
`else
      rr = 1'b1;
`endif
      model_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
